// File: rtl/sha256_job_dispatch_pkg.sv
// Shared types and constants for the double-SHA256 job dispatcher.
// SHA256_DISPATCH_STATS_EN adds a wait-cycle count word to every result frame.
package sha256_dispatch_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam logic [7:0] STATUS_FOUND   = 8'h01;
  localparam logic [7:0] STATUS_TIMEOUT = 8'h02;
  localparam logic [7:0] STATUS_ABORT   = 8'h03;

  localparam int JOB_WORDS   = 34;
  localparam int FOUND_WORDS = 10;

`ifdef SHA256_DISPATCH_STATS_EN
  localparam int STATS_WORDS = 1;
`else
  localparam int STATS_WORDS = 0;
`endif

  // Number of result words emitted for a given exit status.
  function automatic int frame_words(input logic [7:0] status);
    return (status == STATUS_FOUND) ? FOUND_WORDS + STATS_WORDS : 1 + STATS_WORDS;
  endfunction

endpackage

// File: rtl/sha256_job_dispatch_if.sv
// Host job/result streams and engine job/result bus of the dispatcher.
// slave = dispatcher side, master = host plus engine side.
interface sha256_job_dispatch_if;

  logic               s_valid;
  logic               s_ready;
  logic [31:0]        s_data;
  logic               abort;

  logic               m_start;
  logic [63:0][7:0]   m_data;
  logic [7:0][31:0]   m_state;
  logic [31:0]        m_nonce_base;
  logic [31:0][7:0]   m_target;
  logic [31:0]        m_position;
  logic               m_done;
  logic [31:0][7:0]   m_result;
  logic [31:0]        m_nonce;

  logic               r_valid;
  logic               r_ready;
  logic [31:0]        r_data;
  logic               busy;

  modport slave (
    input  s_valid, s_data, abort, m_done, m_result, m_nonce, r_ready,
    output s_ready, m_start, m_data, m_state, m_nonce_base, m_target, m_position,
           r_valid, r_data, busy
  );

  modport master (
    output s_valid, s_data, abort, m_done, m_result, m_nonce, r_ready,
    input  s_ready, m_start, m_data, m_state, m_nonce_base, m_target, m_position,
           r_valid, r_data, busy
  );

endinterface

// File: rtl/sha256_job_dispatch_result_tx.sv
// Result frame serializer: snapshots status/id/nonce/hash on i_start and streams them out.
// SHA256_DISPATCH_STATS_EN inserts the wait-cycle count as word 1.
module sha256_result_tx
  import sha256_dispatch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [7:0]        i_status,
  input  logic [23:0]       i_job_id,
  input  logic [31:0]       i_nonce,
  input  logic [255:0]      i_hash,
`ifdef SHA256_DISPATCH_STATS_EN
  input  logic [CNT_W-1:0]  i_cnt,
`endif
  input  logic              i_ready,
  output logic              o_valid,
  output logic [31:0]       o_data,
  output logic              o_done
);

  logic              r_valid;
  logic [31:0]       r_data;
  logic [3:0]        r_idx;
  logic [3:0]        r_last_idx;
  logic [31:0]       r_nonce;
  logic [255:0]      r_hash;
`ifdef SHA256_DISPATCH_STATS_EN
  logic [CNT_W-1:0]  r_cnt;
`endif

  logic [3:0]        w_next_idx;
  logic [3:0]        w_body_idx;
  logic [2:0]        w_hash_idx;
  logic [31:0]       w_next_word;

  // Body index 0 is the nonce, 1..8 are the hash words.
  assign w_next_idx = r_idx + 4'd1;
  assign w_body_idx = w_next_idx - 4'(STATS_WORDS + 1);
  assign w_hash_idx = 3'(w_body_idx - 4'd1);

  always_comb begin
    w_next_word = (w_body_idx == 4'd0) ? r_nonce : r_hash[{w_hash_idx, 5'b0} +: 32];
`ifdef SHA256_DISPATCH_STATS_EN
    if (w_next_idx == 4'd1) w_next_word = 32'(r_cnt);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_nonce    <= '0;
      r_hash     <= '0;
`ifdef SHA256_DISPATCH_STATS_EN
      r_cnt      <= '0;
`endif
    end else if (i_start) begin
      r_valid    <= 1'b1;
      r_data     <= {i_status, i_job_id};
      r_idx      <= '0;
      r_last_idx <= 4'(frame_words(i_status) - 1);
      r_nonce    <= i_nonce;
      r_hash     <= i_hash;
`ifdef SHA256_DISPATCH_STATS_EN
      r_cnt      <= i_cnt;
`endif
    end else if (r_valid && i_ready) begin
      if (r_idx == r_last_idx) begin
        r_valid <= 1'b0;
      end else begin
        r_idx  <= w_next_idx;
        r_data <= w_next_word;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_done  = r_valid & i_ready & (r_idx == r_last_idx);

endmodule

// File: rtl/sha256_job_dispatch.sv
// Job-side controller for the double-SHA256 engine: loads a 34-word job, starts the
// engine, watches done/abort/timeout and returns a result frame. Option: SHA256_DISPATCH_STATS_EN.
module sha256_job_dispatch
  import sha256_dispatch_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic                  clk,
  input logic                  rst,
  sha256_job_dispatch_if.slave bus
);

  state_t            r_state;
  logic [5:0]        r_word_cnt;
  logic [23:0]       r_job_id;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_timeout;
  logic              r_s_ready;
  logic              r_m_start;
  logic              r_busy;
  logic [255:0]      r_m_state;
  logic [511:0]      r_m_data;
  logic [255:0]      r_m_target;
  logic [31:0]       r_m_nonce_base;

  logic              w_accept;
  logic              w_last_word;
  logic [3:0]        w_data_idx;
  logic [2:0]        w_tgt_idx;
  logic              w_done_ok;
  logic              w_timeout_hit;
  logic              w_exit;
  logic [7:0]        w_status;
  logic              w_tx_done;
  logic              w_r_valid;
  logic [31:0]       w_r_data;

  assign w_accept    = r_s_ready & bus.s_valid;
  assign w_last_word = (r_word_cnt == 6'(JOB_WORDS - 1));
  assign w_data_idx  = 4'(r_word_cnt - 6'd8);
  assign w_tgt_idx   = 3'(r_word_cnt - 6'd24);

  // The first WAIT cycle (cnt == 0) still shows the previous job's found flag.
  assign w_done_ok     = bus.m_done && (r_cnt != '0);
  assign w_timeout_hit = (r_timeout != 32'd0) && (r_cnt == r_timeout[CNT_W-1:0]);

  always_comb begin
    w_exit   = 1'b0;
    w_status = STATUS_FOUND;
    if (r_state == WAIT) begin
      if (w_done_ok) begin
        w_exit   = 1'b1;
        w_status = STATUS_FOUND;
      end else if (bus.abort) begin
        w_exit   = 1'b1;
        w_status = STATUS_ABORT;
      end else if (w_timeout_hit) begin
        w_exit   = 1'b1;
        w_status = STATUS_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= LOAD;
      r_word_cnt     <= '0;
      r_job_id       <= '0;
      r_cnt          <= '0;
      r_timeout      <= '0;
      r_s_ready      <= 1'b1;
      r_m_start      <= 1'b0;
      r_busy         <= 1'b0;
      r_m_state      <= '0;
      r_m_data       <= '0;
      r_m_target     <= '0;
      r_m_nonce_base <= '0;
    end else begin
      r_m_start <= 1'b0;
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            if (r_word_cnt < 6'd8)
              r_m_state[{r_word_cnt[2:0], 5'b0} +: 32] <= bus.s_data;
            else if (r_word_cnt < 6'd24)
              r_m_data[{w_data_idx, 5'b0} +: 32] <= bus.s_data;
            else if (r_word_cnt < 6'd32)
              r_m_target[{w_tgt_idx, 5'b0} +: 32] <= bus.s_data;
            else if (r_word_cnt == 6'd32)
              r_m_nonce_base <= bus.s_data;
            else
              r_timeout <= bus.s_data;

            if (w_last_word) begin
              r_word_cnt <= '0;
              r_state    <= START;
              r_m_start  <= 1'b1;
              r_job_id   <= r_job_id + 24'd1;
              r_s_ready  <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_word_cnt <= r_word_cnt + 6'd1;
            end
          end
        end
        START: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: begin
          // cnt freezes on exit so the stats word equals the compared count
          if (w_exit)
            r_state <= SEND;
          else if (r_cnt != '1)
            r_cnt <= r_cnt + CNT_W'(1);
        end
        SEND: begin
          if (w_tx_done) begin
            r_state   <= LOAD;
            r_s_ready <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  sha256_result_tx #(
    .CNT_W (CNT_W)
  ) u_result_tx (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_exit),
    .i_status (w_status),
    .i_job_id (r_job_id),
    .i_nonce  (bus.m_nonce),
    .i_hash   (bus.m_result),
`ifdef SHA256_DISPATCH_STATS_EN
    .i_cnt    (r_cnt),
`endif
    .i_ready  (bus.r_ready),
    .o_valid  (w_r_valid),
    .o_data   (w_r_data),
    .o_done   (w_tx_done)
  );

  assign bus.s_ready      = r_s_ready;
  assign bus.busy         = r_busy;
  assign bus.m_start      = r_m_start;
  assign bus.m_state      = r_m_state;
  assign bus.m_data       = r_m_data;
  assign bus.m_target     = r_m_target;
  assign bus.m_nonce_base = r_m_nonce_base;
  assign bus.m_position   = {8'd0, r_job_id};
  assign bus.r_valid      = w_r_valid;
  assign bus.r_data       = w_r_data;

endmodule

// File: tb/tb_sha256_job_dispatch.sv
// Randomized bench for sha256_job_dispatch: host, engine model and frame scoreboard.
module tb_sha256_job_dispatch;
  import sha256_dispatch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sha256_job_dispatch_if bus();

  sha256_job_dispatch #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_id = 0;
  logic [31:0] jw [34];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.abort   = 1'b0;
    bus.m_done  = 1'b0;
    bus.r_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_id = 0;
  endtask

  // One full job: load, engine behaviour, frame collection and scoreboard.
  task automatic run_job(input logic [31:0] nonce_base, input logic [31:0] timeout,
                         input int done_at, input int abort_at, input bit stale,
                         input int ready_mode, input bit fixed_hash, input logic [31:0] eng_nonce);
    logic [7:0]       hb [32];
    logic [31:0]      exp_q [$];
    logic [7:0][31:0] exp_state;
    logic [63:0][7:0] exp_data;
    logic [31:0][7:0] exp_target;
    logic [7:0]       status;
    int i, cyc, c, found_k, abort_k, tout_k, exit_k, seen_k, got_n, extra_starts;
    localparam int INF = 1 << 30;

    for (int k = 0; k < JOB_WORDS; k++) jw[k] = $urandom;
    jw[32] = nonce_base;
    jw[33] = timeout;
    for (int j = 0; j < 32; j++) hb[j] = fixed_hash ? 8'(j) : 8'($urandom);
    for (int j = 0; j < 32; j++) bus.m_result[j] = hb[j];
    bus.m_nonce = eng_nonce;
    for (int k = 0; k < 8; k++) exp_state[k] = jw[k];
    for (int j = 0; j < 64; j++) exp_data[j] = 8'(jw[8 + j / 4] >> (8 * (j % 4)));
    for (int j = 0; j < 32; j++) exp_target[j] = 8'(jw[24 + j / 4] >> (8 * (j % 4)));

    check("load_s_ready", 512'(bus.s_ready), 512'(1));
    check("load_busy", 512'(bus.busy), 512'(0));
    bus.m_done = stale;
    i = 0;
    cyc = 0;
    while (i < JOB_WORDS && cyc < 1000) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.s_data  = jw[i];
      bus.abort   = 1'($urandom_range(0, 1));
      if (bus.s_valid && bus.s_ready) i++;
      @(negedge clk);
      cyc++;
    end
    check("load_words", 512'(i), 512'(JOB_WORDS));

    // START cycle
    bus.s_valid = 1'b0;
    bus.abort   = 1'($urandom_range(0, 1));
    exp_id = (exp_id + 1) % (1 << 24);
    check("m_start", 512'(bus.m_start), 512'(1));
    check("m_position", 512'(bus.m_position), 512'(exp_id));
    check("m_state", 512'(bus.m_state), 512'(exp_state));
    check("m_data", 512'(bus.m_data), 512'(exp_data));
    check("m_target", 512'(bus.m_target), 512'(exp_target));
    check("m_nonce_base", 512'(bus.m_nonce_base), 512'(nonce_base));

    // Expected exit: WAIT cycles numbered from 1; cnt in cycle k is k-1.
    found_k = (done_at == 0) ? INF : ((done_at < 2) ? 2 : done_at);
    abort_k = (abort_at == 0) ? INF : abort_at;
    tout_k  = (timeout == 0) ? INF : int'(timeout) + 1;
    exit_k  = found_k;
    status  = STATUS_FOUND;
    if (abort_k < exit_k) begin exit_k = abort_k; status = STATUS_ABORT; end
    if (tout_k < exit_k) begin exit_k = tout_k; status = STATUS_TIMEOUT; end

    exp_q.delete();
    exp_q.push_back({status, 24'(exp_id)});
`ifdef SHA256_DISPATCH_STATS_EN
    exp_q.push_back(32'(exit_k - 1));
`endif
    if (status == STATUS_FOUND) begin
      exp_q.push_back(eng_nonce);
      for (int k = 0; k < 8; k++)
        exp_q.push_back({hb[4*k+3], hb[4*k+2], hb[4*k+1], hb[4*k]});
    end

    seen_k = -1;
    extra_starts = 0;
    for (c = 1; c <= exit_k + 3; c++) begin
      @(negedge clk);
      if (bus.r_valid) begin
        seen_k = c - 1;
        break;
      end
      if (bus.m_start) extra_starts++;
      check("s_ready_busy", 512'({bus.s_ready, bus.busy}), 512'(2'b01));
      bus.m_done = (stale && c == 1) || (done_at != 0 && c >= done_at);
      bus.abort  = (c == abort_at);
    end
    bus.abort = 1'b0;
    check("exit_cycle", 512'(32'(seen_k)), 512'(32'(exit_k)));

    got_n = 0;
    cyc = 0;
    if (seen_k >= 0) begin
      while (got_n < exp_q.size() && cyc < 300) begin
        case (ready_mode)
          0:       bus.r_ready = 1'b1;
          1:       bus.r_ready = (cyc % 2 == 0);
          default: bus.r_ready = ($urandom_range(0, 3) != 0);
        endcase
        if (bus.m_start) extra_starts++;
        if (bus.r_valid && bus.r_ready) begin
          check($sformatf("word%0d", got_n), 512'(bus.r_data), 512'(exp_q[got_n]));
          got_n++;
        end
        @(negedge clk);
        cyc++;
      end
      bus.r_ready = 1'b0;
    end
    check("frame_len", 512'(got_n), 512'(exp_q.size()));
    check("post_s_ready", 512'(bus.s_ready), 512'(1));
    check("post_r_valid", 512'(bus.r_valid), 512'(0));
    check("post_m_data", 512'(bus.m_data), 512'(exp_data));
    check("extra_starts", 512'(extra_starts), 512'(0));
    $display("job id=%06h status=%02h words=%0d exit_cycle=%0d", exp_id, status, got_n, seen_k);
    if (seen_k < 0 || got_n != exp_q.size()) do_reset();
  endtask

  initial begin
    int n;
    int t, d, a;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.abort    = 1'b0;
    bus.m_done   = 1'b0;
    bus.m_result = '0;
    bus.m_nonce  = '0;
    bus.r_ready  = 1'b0;
    do_reset();

    check("rst_s_ready", 512'(bus.s_ready), 512'(1));
    check("rst_busy", 512'(bus.busy), 512'(0));
    check("rst_m_start", 512'(bus.m_start), 512'(0));
    check("rst_r_valid", 512'(bus.r_valid), 512'(0));
    check("rst_r_data", 512'(bus.r_data), 512'(0));
    check("rst_m_position", 512'(bus.m_position), 512'(0));
    check("rst_m_data", 512'(bus.m_data), 512'(0));
    check("rst_m_nonce_base", 512'(bus.m_nonce_base), 512'(0));

    run_job(32'h10, 32'd0, 50, 0, 1'b0, 0, 1'b1, 32'h13);       // found, fixed hash
    run_job($urandom, 32'd0, 30, 0, 1'b1, 2, 1'b0, $urandom);   // stale done ignored
    run_job($urandom, 32'd100, 0, 0, 1'b0, 0, 1'b0, $urandom);  // timeout
    run_job($urandom, 32'd0, 0, 5, 1'b1, 0, 1'b0, $urandom);    // abort, late done before start
    run_job($urandom, 32'd0, 7, 7, 1'b0, 0, 1'b0, $urandom);    // abort ties with done
    run_job($urandom, 32'd0, 40, 0, 1'b0, 1, 1'b0, $urandom);   // toggled r_ready

    // Reset in the middle of a job load
    n = 0;
    while (n < 20) begin
      bus.s_valid = 1'b1;
      bus.s_data  = $urandom;
      if (bus.s_ready) n++;
      @(negedge clk);
    end
    do_reset();
    $display("reset after %0d job words", n);
    check("mid_rst_s_ready", 512'(bus.s_ready), 512'(1));
    check("mid_rst_busy", 512'(bus.busy), 512'(0));
    check("mid_rst_job_id", 512'(bus.m_position), 512'(0));
    run_job($urandom, 32'd0, 20, 0, 1'b0, 0, 1'b0, $urandom);

    for (int r = 0; r < 12; r++) begin
      t = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 60) : 0;
      d = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 80);
      a = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : 0;
      if (t == 0 && d == 0 && a == 0) a = $urandom_range(1, 20);
      run_job($urandom, 32'(t), d, a, 1'($urandom_range(0, 1)),
              $urandom_range(0, 2), 1'b0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_job_dispatch.md
# sha256_job_dispatch

Job-side controller for the double-SHA256 nonce search engine. Accepts a mining job as a 32-bit word stream from the host interface, assembles it into the engine's wide job inputs, and issues the start pulse. It then watches the engine's result, applying an optional cycle timeout and an abort request. It returns a result frame to the host as a 32-bit word stream. It is the initiator/consumer end of the engine's job/result interface.

## Interface
- CNT_W, 32: width of the wait-cycle counter and of the timeout compare (1..32)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  job word valid
- s_ready  out  1  job word accepted when s_valid & s_ready
- s_data  in  32  job word
- abort  in  1  single-cycle request to abandon the current search
- m_start  out  1  one-cycle start pulse to engine
- m_data  out  64x8  block bytes
- m_state  out  8x32  midstate
- m_nonce_base  out  32  first nonce
- m_target  out  32x8  target
- m_position  out  32  job id, zero-extended
- m_done  in  1  engine found-flag (level, held until next start)
- m_result  in  32x8  engine hash
- m_nonce  in  32  engine winning nonce
- r_valid  out  1  result word valid
- r_ready  in  1  result word accepted when r_valid & r_ready
- r_data  out  32  result word
- busy  out  1  high in every state except LOAD

## Operation
- States: LOAD, START, WAIT, SEND.
- LOAD: s_ready=1. Accepts 34 words in fixed order:
  - words 0–7: m_state[0..7]
  - words 8–23: m_data bytes 4i..4i+3 for i=0..15, with byte 4i = s_data[7:0]
  - words 24–31: m_target bytes, same packing
  - word 32: m_nonce_base
  - word 33: timeout
- The 34th accepted word moves to START. The word counter is 6-bit and returns to 0 on that transition.
- START: m_start=1 for exactly one cycle, then WAIT. At the START entry edge the job id (24-bit) increments, wrapping 0xFFFFFF→0. m_position shows the new id from that edge.
- WAIT: cycle counter cnt (CNT_W bits) clears on entry, increments each WAIT cycle and saturates at all-ones. m_done is ignored during START and the first WAIT cycle, because the engine still shows the previous job's flag then. Exit conditions, in priority order:
  - m_done=1 → status 0x01 FOUND; capture m_nonce and m_result.
  - abort=1 → status 0x03 ABORT.
  - timeout≠0 and cnt == timeout[CNT_W-1:0] → status 0x02 TIMEOUT.
  - Timeout 0 disables the timeout.
- SEND: emits the frame, then returns to LOAD.
  - Header: {status[7:0], job_id[23:0]}.
  - FOUND frames continue with the nonce word, then hash words 0–7, where word i = m_result bytes 4i..4i+3 with byte 4i at bits [7:0]. Total 10 words.
  - TIMEOUT and ABORT frames are header only.
- abort outside WAIT has no effect. m_done outside the WAIT sampling window has no effect.
- After TIMEOUT or ABORT the engine keeps searching. The next job's m_start restarts it, and any late m_done before then is ignored.

## Timing
- Reset values:
  - state LOAD
  - s_ready 1
  - m_start 0
  - r_valid 0
  - r_data 0
  - busy 0
  - job id 0
  - cnt 0
  - all m_* data outputs 0
- Reset mid-frame drops both the partial job and any pending result frame.
- One job word per cycle maximum. A gap in s_valid stalls loading with no timeout.
- Last job word accepted at edge N: m_start=1 in cycle N+1, WAIT from N+2, m_done sampled from N+3.
- m_done seen at edge M: r_valid=1 from cycle M+1.
- r_data is registered and holds while r_valid & !r_ready. The next word is presented the cycle after acceptance.
- After the last frame word is accepted, s_ready=1 in the next cycle.
- m_* data outputs are stable from START until the next job's word 0 is accepted.

## Configuration
- SHA256_DISPATCH_STATS_EN defined: every frame carries cnt, zero-extended to 32 bits, as word 1 directly after the header. FOUND frames become 11 words and TIMEOUT/ABORT frames become 2 words.
- Undefined: frames are exactly as in Operation, and the stats word logic is absent.

## Structure
- Package sha256_dispatch_pkg holds:
  - the state enum
  - status constants STATUS_FOUND/TIMEOUT/ABORT
  - JOB_WORDS=34
  - FOUND_WORDS=10
- One sub-module, sha256_result_tx: a frame serializer taking a status/job id/nonce/hash snapshot plus a start pulse, driving r_valid/r_data and returning done. The dispatcher FSM and job assembly stay in the top.

## Test plan
- 34-word job with nonce_base 0x00000010 and timeout 0; model asserts m_done after 50 cycles with nonce 0x00000013 and hash bytes 0x00..0x1F → frame 0x01000001, 0x00000013, 0x03020100 … 0x1F1E1D1C; m_start pulses exactly once.
- Timeout word 100, no m_done → after 100 WAIT cycles header 0x02000001, single word; s_ready=1 in the cycle after acceptance.
- abort pulse in WAIT cycle 5 → 0x03000001. abort and m_done in the same cycle → FOUND frame.
- Stale m_done=1 held over from the previous job through START and the first WAIT cycle, then dropped → no result frame; the later real m_done produces job id 2.
- r_ready toggled 1/0 every cycle → all 10 words delivered in order with no duplicates; with SHA256_DISPATCH_STATS_EN defined, word 1 equals the measured WAIT count.
- rst asserted after 20 job words → s_ready=1, busy=0, job id 0; a fresh full job completes normally.
